// File: rtl/sseg_pkg.sv
// sseg_pkg: glyph constants, controller state type and segment polarity helper
package sseg_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF = 7'h00;
  typedef enum logic [1:0] {IDLE, DECODE, COMMIT} state_t;
  function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input bit active_low);
    return active_low ? ~seg : seg;
  endfunction
endpackage

// File: rtl/hex_sseg_decode.sv
// hex_sseg_decode: nibble to active-high {g..a} glyph plus BCD-range flag
module hex_sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg,
  output logic       is_bcd
);
  always_comb begin
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    is_bcd = nibble < 4'd10;
  end
endmodule

// File: rtl/sseg_display_ctrl.sv
// sseg_display_ctrl: registered multi-digit seven-segment controller with
// handshake load, blank/blink masks, leading-zero suppression and BCD check
module sseg_display_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter bit HEX_MODE   = 1,
  parameter bit ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  input  logic                    i_lzs_en,
  output logic [7*NUM_DIGITS-1:0] o_sseg,
  output logic                    o_err
);
  localparam int N = NUM_DIGITS;
  localparam int CW = $clog2(BLINK_DIV);
  state_t state, state_d;
  logic [4*N-1:0] cap_value;
  logic [N-1:0] cap_blank, cap_blink, is_bcd, lzs, pipe_dark, pipe_blink, disp_dark, disp_blink, use_dark, use_blink;
  logic cap_lzs, pipe_err, lead, commit, wrap, off, off_d;
  logic [7*N-1:0] dec_seg, pipe_seg, disp_seg, use_seg, sseg_d;
  logic [CW-1:0] cnt, cnt_d;
  for (genvar g = 0; g < N; g++) begin : g_dec
    logic [6:0] raw;
    hex_sseg_decode u_dec (.nibble(cap_value[4*g+:4]), .seg(raw), .is_bcd(is_bcd[g]));
    assign dec_seg[7*g+:7] = (!HEX_MODE && !is_bcd[g]) ? SEG_DASH : raw;
  end
  // MSB-first scan: digits stay dark while every higher digit was zero; digit 0 always shows
  always_comb begin
    lzs = '0;
    lead = cap_lzs;
    for (int i = N - 1; i > 0; i--) begin
      lead = lead && (cap_value[4*i+:4] == 4'd0);
      lzs[i] = lead;
    end
  end
  assign commit = state == COMMIT;
  assign wrap = cnt == CW'(BLINK_DIV - 1);
  assign use_seg = commit ? pipe_seg : disp_seg;
  assign use_dark = commit ? pipe_dark : disp_dark;
  assign use_blink = commit ? pipe_blink : disp_blink;
  // the output register sees the phase it will hold after this edge, so a commit shows VISIBLE at once
  always_comb begin
    state_d = state == IDLE ? (i_valid ? DECODE : IDLE) : state == DECODE ? COMMIT : IDLE;
    cnt_d = (commit || wrap) ? '0 : cnt + 1'b1;
    off_d = commit ? 1'b0 : wrap ? ~off : off;
    sseg_d = '0;
    for (int i = 0; i < N; i++)
      sseg_d[7*i+:7] = seg_polarity((use_dark[i] || (off_d && use_blink[i])) ? SEG_OFF : use_seg[7*i+:7], ACTIVE_LOW);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      o_ready <= 1'b1;
      o_err <= 1'b0;
      o_sseg <= {N{seg_polarity(SEG_OFF, ACTIVE_LOW)}};
      cnt <= '0;
      off <= 1'b0;
      cap_value <= '0;
      cap_blank <= '0;
      cap_blink <= '0;
      cap_lzs <= 1'b0;
      pipe_seg <= '0;
      pipe_dark <= '0;
      pipe_blink <= '0;
      pipe_err <= 1'b0;
      disp_seg <= '0;
      disp_dark <= '1;
      disp_blink <= '0;
    end else begin
      state <= state_d;
      o_ready <= state_d == IDLE;
      cnt <= cnt_d;
      off <= off_d;
      o_sseg <= sseg_d;
      if (state == IDLE && i_valid) begin
        cap_value <= i_value;
        cap_blank <= i_blank_mask;
        cap_blink <= i_blink_mask;
        cap_lzs <= i_lzs_en;
      end
      if (state == DECODE) begin
        pipe_seg <= dec_seg;
        pipe_dark <= cap_blank | lzs;
        pipe_blink <= cap_blink;
        pipe_err <= !HEX_MODE && !(&is_bcd);
      end
      if (commit) begin
        disp_seg <= pipe_seg;
        disp_dark <= pipe_dark;
        disp_blink <= pipe_blink;
        o_err <= pipe_err;
      end
    end
  end
endmodule
